// File: rtl/dma_fpram.sv
// DRAM-to-FPRAM DMA channel: copies a block of 16-bit words from DRAM
// into the palette RAM (CRAM) or the sprite file (SFILE).
module dma_fpram #(
    parameter int DA_W   = 21,
    parameter int MAXOUT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [DA_W-1:0] cfg_saddr,
    input  logic [7:0]      cfg_daddr,
    input  logic [7:0]      cfg_len,
    input  logic            cfg_sfile,
    output logic [DA_W-1:0] dram_addr,
    output logic            dram_req,
    input  logic            dram_next,
    input  logic [15:0]     dram_rdat,
    input  logic            dram_stb,
    output logic [15:0]     dma_data,
    output logic [7:0]      dma_wraddr,
    output logic            dma_cram_we,
    output logic            dma_sfile_we,
    output logic            busy,
    output logic            done
);

    localparam int OW = $clog2(MAXOUT + 1);
    localparam logic [OW-1:0] MAXO = OW'(MAXOUT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    logic [DA_W-1:0] src;
    logic [7:0]      dst;
    logic [8:0]      issue_left;
    logic [8:0]      recv_left;
    logic [OW-1:0]   outstanding;
    logic            tgt;

    logic            acc;
    logic            ret;
    logic [OW-1:0]   out_nxt;
    logic [8:0]      recv_nxt;

    assign dram_req  = (state == RUN) && (issue_left != 9'd0)
                     && (outstanding < MAXO);
    assign dram_addr = src;
    assign acc       = dram_req && dram_next;
    assign ret       = dram_stb && (outstanding != '0);

    // Next values of the in-flight and remaining-return counters
    always_comb begin
        out_nxt  = outstanding;
        recv_nxt = recv_left;
        if (acc && !ret)
            out_nxt = outstanding + OW'(1);
        else if (!acc && ret)
            out_nxt = outstanding - OW'(1);
        if (ret)
            recv_nxt = recv_left - 9'd1;
    end

    // Transfer sequencing, request bookkeeping and registered FPRAM writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            src          <= '0;
            dst          <= '0;
            issue_left   <= '0;
            recv_left    <= '0;
            outstanding  <= '0;
            tgt          <= 1'b0;
            dma_data     <= '0;
            dma_wraddr   <= '0;
            dma_cram_we  <= 1'b0;
            dma_sfile_we <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            dma_cram_we  <= 1'b0;
            dma_sfile_we <= 1'b0;
            outstanding  <= out_nxt;
            recv_left    <= recv_nxt;
            if (acc) begin
                src        <= src + DA_W'(1);
                issue_left <= issue_left - 9'd1;
            end
            if (ret) begin
                dma_data     <= dram_rdat;
                dma_wraddr   <= dst;
                dst          <= dst + 8'd1;
                dma_sfile_we <= tgt;
                dma_cram_we  <= !tgt;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        src        <= cfg_saddr;
                        dst        <= cfg_daddr;
                        issue_left <= {1'b0, cfg_len} + 9'd1;
                        recv_left  <= {1'b0, cfg_len} + 9'd1;
                        tgt        <= cfg_sfile;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (ret && recv_nxt == 9'd0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (abort) begin
                        issue_left <= '0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_nxt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_fpram.sv
// Testbench for dma_fpram: a DRAM/arbiter model feeds randomized grants
// and latencies; a write list derived from the config checks every strobe.
module tb_dma_fpram;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [20:0] cfg_saddr;
    logic [7:0]  cfg_daddr;
    logic [7:0]  cfg_len;
    logic        cfg_sfile;
    logic [20:0] dram_addr;
    logic        dram_req;
    logic        dram_next;
    logic [15:0] dram_rdat;
    logic        dram_stb;
    logic [15:0] dma_data;
    logic [7:0]  dma_wraddr;
    logic        dma_cram_we;
    logic        dma_sfile_we;
    logic        busy;
    logic        done;

    dma_fpram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cfg_saddr    (cfg_saddr),
        .cfg_daddr    (cfg_daddr),
        .cfg_len      (cfg_len),
        .cfg_sfile    (cfg_sfile),
        .dram_addr    (dram_addr),
        .dram_req     (dram_req),
        .dram_next    (dram_next),
        .dram_rdat    (dram_rdat),
        .dram_stb     (dram_stb),
        .dma_data     (dma_data),
        .dma_wraddr   (dma_wraddr),
        .dma_cram_we  (dma_cram_we),
        .dma_sfile_we (dma_sfile_we),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tgt;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int checks   = 0;
    int failures = 0;

    wr_t         exp_q[$];
    logic [20:0] pend_a[$];
    int          pend_t[$];

    int          cyc       = 0;
    int          n_acc     = 0;
    int          n_wr      = 0;
    int          done_cnt  = 0;
    int          done_wr   = 0;
    logic        done_busy = 1'b0;
    logic [20:0] cur_saddr = '0;
    int          grant_pct = 100;
    int          acc_cap   = 100000;
    int          lat_min   = 2;
    int          lat_max   = 2;
    bit          hold      = 1'b0;
    bit          stray     = 1'b0;

    // DRAM contents: a fixed scramble of the word address
    function automatic logic [15:0] mem(input logic [20:0] a);
        logic [31:0] t;
        t = {11'd0, a} * 32'h9E37_79B1;
        return t[27:12];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_req"}, 32'(dram_req), 0);
        chk({pfx, "_cram_we"}, 32'(dma_cram_we), 0);
        chk({pfx, "_sfile_we"}, 32'(dma_sfile_we), 0);
        chk({pfx, "_dram_addr"}, 32'(dram_addr), 0);
        chk({pfx, "_dma_data"}, 32'(dma_data), 0);
        chk({pfx, "_wraddr"}, 32'(dma_wraddr), 0);
    endtask

    // One clock: observe outputs at the falling edge, then drive the
    // arbiter grant and in-order read returns for the next rising edge.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (dma_cram_we || dma_sfile_we) begin
            n_wr++;
            chk("we_exclusive", 32'(dma_cram_we & dma_sfile_we), 0);
            chk("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(dma_wraddr), 32'(e.a));
                chk("wr_data", 32'(dma_data), 32'(e.d));
                chk("wr_tgt", 32'({dma_sfile_we, dma_cram_we}),
                    e.tgt ? 32'd2 : 32'd1);
            end
        end
        if (done) begin
            done_cnt++;
            done_wr   = n_wr;
            done_busy = busy;
        end
        if (pend_a.size() >= 3)
            chk("req_limit", 32'(dram_req), 0);
        dram_next = (n_acc < acc_cap)
                  && ($urandom_range(99) < 32'(grant_pct));
        if (dram_req && dram_next) begin
            chk("rd_addr", 32'(dram_addr),
                32'(21'(cur_saddr + 21'(n_acc))));
            pend_a.push_back(dram_addr);
            pend_t.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            n_acc++;
        end
        dram_stb  = 1'b0;
        dram_rdat = 16'($urandom);
        if (stray) begin
            dram_stb = 1'b1;
        end else if (!hold && pend_a.size() != 0
                     && pend_t[0] <= cyc) begin
            dram_stb  = 1'b1;
            dram_rdat = mem(pend_a.pop_front());
            void'(pend_t.pop_front());
        end
    endtask

    task automatic begin_xfer(input logic [20:0] sa, input logic [7:0] da,
                              input logic [7:0] len, input logic sf);
        cur_saddr = sa;
        n_acc     = 0;
        n_wr      = 0;
        done_cnt  = 0;
        for (int i = 0; i <= int'(len); i++)
            exp_q.push_back('{sf, 8'(da + 8'(i)), mem(21'(sa + 21'(i)))});
        cfg_saddr = sa;
        cfg_daddr = da;
        cfg_len   = len;
        cfg_sfile = sf;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic run_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", 32'(done_cnt != 0), 1);
        chk("busy_low_at_done", 32'(done_busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_saddr = '0;
        cfg_daddr = '0;
        cfg_len   = '0;
        cfg_sfile = 1'b0;
        dram_next = 1'b0;
        dram_rdat = '0;
        dram_stb  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Basic CRAM copy, grant every cycle, fixed latency 2
        grant_pct = 100;
        lat_min   = 2;
        lat_max   = 2;
        begin_xfer(21'h00100, 8'h10, 8'd3, 1'b0);
        run_done(60);
        chk("basic_accepts", 32'(n_acc), 4);
        chk("basic_writes", 32'(n_wr), 4);
        chk("basic_done_with_last", 32'(done_wr), 4);
        repeat (3) tick();
        chk("basic_busy_after", 32'(busy), 0);
        chk("basic_single_done", 32'(done_cnt), 1);

        // FPRAM address wrap into SFILE; abort alongside start is ignored
        grant_pct = 70;
        lat_min   = 1;
        lat_max   = 3;
        abort     = 1'b1;
        begin_xfer(21'($urandom), 8'hFE, 8'd3, 1'b1);
        run_done(100);
        chk("wrap_writes", 32'(n_wr), 4);
        chk("wrap_exp_empty", 32'(exp_q.size()), 0);

        // Outstanding limit with no returns, then release
        grant_pct = 100;
        hold      = 1'b1;
        begin_xfer(21'($urandom), 8'($urandom), 8'd7, 1'b0);
        repeat (6) tick();
        chk("limit_accepts", 32'(n_acc), 3);
        chk("limit_req_low", 32'(dram_req), 0);
        hold = 1'b0;
        run_done(200);
        chk("limit_writes", 32'(n_wr), 8);
        chk("limit_exp_empty", 32'(exp_q.size()), 0);

        // Abort after six grants with two reads still pending
        lat_min = 2;
        lat_max = 2;
        acc_cap = 6;
        begin_xfer(21'($urandom), 8'($urandom), 8'd15, 1'b1);
        for (int k = 0; k < 50 && n_acc < 6; k++)
            tick();
        chk("abort_pending", 32'(pend_a.size()), 2);
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        acc_cap = 100000;
        run_done(60);
        repeat (4) tick();
        chk("abort_accepts", 32'(n_acc), 6);
        chk("abort_writes", 32'(n_wr), 6);
        chk("abort_busy_after", 32'(busy), 0);
        exp_q.delete();

        // Start while busy is ignored
        begin_xfer(21'h01234, 8'h40, 8'd5, 1'b0);
        repeat (2) tick();
        cfg_saddr = 21'h0ABCD;
        cfg_daddr = 8'h99;
        cfg_len   = 8'd200;
        cfg_sfile = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        run_done(100);
        chk("busy_start_accepts", 32'(n_acc), 6);
        chk("busy_start_writes", 32'(n_wr), 6);
        chk("busy_start_exp_empty", 32'(exp_q.size()), 0);

        // Maximum length with random grants/latency and source wrap
        grant_pct = 60;
        lat_min   = 1;
        lat_max   = 4;
        begin_xfer(21'h1FFFF0, 8'($urandom), 8'd255, 1'($urandom));
        run_done(4000);
        chk("max_writes", 32'(n_wr), 256);
        chk("max_done_with_last", 32'(done_wr), 256);
        chk("max_exp_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-transfer
        grant_pct = 100;
        lat_min   = 2;
        lat_max   = 2;
        begin_xfer(21'($urandom), 8'($urandom), 8'd20, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        exp_q.delete();
        pend_a.delete();
        pend_t.delete();
        dram_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_wr  = 0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (3) tick();
        chk("stray_stb_writes", 32'(n_wr), 0);
        chk("stray_busy", 32'(busy), 0);
        begin_xfer(21'($urandom), 8'($urandom), 8'd9, 1'b1);
        run_done(200);
        chk("post_rst_writes", 32'(n_wr), 10);
        chk("post_rst_exp_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_fpram.md
Name: dma_fpram

Overview:
- DRAM-to-FPGA-RAM DMA channel. Copies a block of 16-bit words from DRAM into the palette RAM (CRAM) or the sprite file (SFILE).
- Sits directly upstream of the Z80 memory-map block and drives its dma_data/dma_wraddr/dma_cram_we/dma_sfile_we inputs. While this block writes, it takes priority over Z80 writes.
- Z80 port logic loads the configuration and pulses start. DRAM reads go through the shared arbiter's request/next/strobe protocol.

Parameters:
- DA_W, 21, DRAM word-address width.
- MAXOUT, 3, maximum DRAM reads issued but not yet returned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches cfg_* and begins a transfer
- abort  in  1  one-cycle pulse; stops issuing new reads
- cfg_saddr  in  DA_W  DRAM source word address
- cfg_daddr  in  8  FPRAM destination word address
- cfg_len  in  8  word count minus 1 (0 = 1 word, 255 = 256 words)
- cfg_sfile  in  1  0 = CRAM target, 1 = SFILE target
- dram_addr  out  DA_W  current read address
- dram_req  out  1  read request to arbiter
- dram_next  in  1  arbiter accepted the request at dram_addr this cycle
- dram_rdat  in  16  read data
- dram_stb  in  1  dram_rdat valid; returns are in request order
- dma_data  out  16  word to FPRAM
- dma_wraddr  out  8  FPRAM word address
- dma_cram_we  out  1  CRAM write strobe
- dma_sfile_we  out  1  SFILE write strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE; busy=0, done=0, dram_req=0, dma_cram_we=0, dma_sfile_we=0; dram_addr=0, dma_data=0, dma_wraddr=0; all counters 0. Reset mid-transfer abandons it; late dram_stb pulses after reset release are ignored in IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start loads src=cfg_saddr, dst=cfg_daddr, issue_left=cfg_len+1 (9-bit), recv_left=cfg_len+1, tgt=cfg_sfile.
  - Next cycle: RUN, busy=1.
- start is ignored when state is not IDLE. start and abort in the same cycle in IDLE: start wins.
- Request side:
  - dram_req = (state==RUN) && issue_left!=0 && outstanding<MAXOUT. It is combinational from registers, so it drops the same cycle the limit is hit.
  - dram_addr = src.
  - On dram_next while dram_req: src+1 (wraps modulo 2^DA_W), issue_left−1, outstanding+1.
- Return side, on dram_stb with outstanding!=0:
  - Next cycle: dma_data=dram_rdat, dma_wraddr=dst. dma_sfile_we=tgt or dma_cram_we=!tgt, high exactly one cycle (latency 1).
  - dst+1 wraps 255→0. recv_left−1, outstanding−1.
  - dram_stb with outstanding==0 is ignored, with no write strobe.
- dram_next and dram_stb in the same cycle: outstanding is unchanged; both counters update.
- Completion: when recv_left reaches 0, go to IDLE the next cycle. done pulses 1 cycle coincident with the final write strobe. busy drops the same cycle.
- abort in RUN:
  - Set issue_left=0 and go to DRAIN.
  - In DRAIN, returning words are still written to FPRAM (data is coherent up to the abort point).
  - When outstanding==0: IDLE, done pulse.
  - abort in DRAIN or IDLE has no effect.
- Write strobes are never both high. dma_data and dma_wraddr hold their last values between strobes.
- DRAM-address widths in bits are fixed. The length counter is 9 bits, so cfg_len=255 transfers exactly 256 words.

Test Plan:
- Basic CRAM copy: cfg_saddr=0x00100, daddr=0x10, len=3, sfile=0, arbiter grants every cycle, data returns 2 cycles later.
  -> dram_addr 0x100..0x103 accepted; CRAM strobes at wraddr 0x10..0x13 carrying the returned data; done with the 4th strobe; busy low after.
- FPRAM address wrap: daddr=0xFE, len=3, sfile=1.
  -> SFILE writes at 0xFE, 0xFF, 0x00, 0x01; dma_cram_we never high.
- Back-pressure and outstanding limit: arbiter grants 5 consecutive cycles, no dram_stb, len=7.
  -> exactly 3 dram_next accepted; dram_req low until a dram_stb arrives; all 8 words eventually written in order.
- Abort: len=15; abort after 6 grants with 2 outstanding.
  -> no further requests; the 2 pending words are written; done pulses; total writes=6.
- Start while busy, and max length: start during RUN with different cfg.
  -> ignored. Then len=255 -> exactly 256 strobes, dst wraps to the start value.
- Async reset mid-transfer: rst_n low during RUN.
  -> all outputs 0 immediately. A stray dram_stb after release produces no strobe; a new start runs normally.
